// File: rtl/keyed_mux_lock_if.sv
// Bus bundle for keyed_mux_lock_unit: serial key delivery, candidate inputs and registered mux results.
interface keyed_mux_lock_if #(
    parameter int NUM_MUX = 10,
    parameter int SEL_W   = 2
);
    localparam int KEY_LEN = NUM_MUX * SEL_W;
    localparam int CNT_W   = $clog2(KEY_LEN + 2);

    logic                            key_in;
    logic                            key_shift;
    logic                            key_commit;
    logic                            key_clear;
    logic [NUM_MUX*(2**SEL_W)-1:0]   cand_i;
    logic                            in_valid;
    logic [NUM_MUX-1:0]              mux_o;
    logic                            out_valid;
    logic                            key_ready;
    logic                            key_err;
    logic [CNT_W-1:0]                key_cnt;

    modport master (
        output key_in, key_shift, key_commit, key_clear, cand_i, in_valid,
        input  mux_o, out_valid, key_ready, key_err, key_cnt
    );

    modport slave (
        input  key_in, key_shift, key_commit, key_clear, cand_i, in_valid,
        output mux_o, out_valid, key_ready, key_err, key_cnt
    );
endinterface

// File: rtl/keyed_mux_lock_unit.sv
// NUM_MUX key-selected 2^SEL_W:1 locking muxes with a serially loaded, commit-gated key.
// Optional trailing even-parity key bit enabled by defining KEY_PARITY_EN.
module keyed_mux_lock_unit #(
    parameter int NUM_MUX = 10,
    parameter int SEL_W   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    keyed_mux_lock_if.slave bus
);
    localparam int KEY_LEN = NUM_MUX * SEL_W;
    localparam int NCAND   = 2 ** SEL_W;
    localparam int CNT_W   = $clog2(KEY_LEN + 2);
`ifdef KEY_PARITY_EN
    localparam int FULL = KEY_LEN + 1;
`else
    localparam int FULL = KEY_LEN;
`endif
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FULL);

    typedef enum logic [1:0] {EMPTY, LOADING, ACTIVE, ERROR} state_e;

    state_e               state_q;
    logic [KEY_LEN-1:0]   key_sr_q;
    logic [CNT_W-1:0]     key_cnt_q;
    logic [NUM_MUX-1:0]   mux_q;
    logic [NUM_MUX-1:0]   mux_d;
    logic                 out_valid_q;
    logic                 loadable;
    logic                 full_ok;

    assign loadable = (state_q == EMPTY) || (state_q == LOADING);

`ifdef KEY_PARITY_EN
    logic par_q;
    assign full_ok = (key_cnt_q == FULL_CNT) && !par_q;
`else
    assign full_ok = (key_cnt_q == FULL_CNT);
`endif

    // Key/control FSM; clear beats commit beats shift.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.key_clear) begin
            state_q   <= EMPTY;
            key_sr_q  <= '0;
            key_cnt_q <= '0;
`ifdef KEY_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else if (loadable) begin
            if (bus.key_commit) begin
                state_q <= full_ok ? ACTIVE : ERROR;
            end else if (bus.key_shift && (key_cnt_q != FULL_CNT)) begin
                state_q   <= LOADING;
                key_cnt_q <= key_cnt_q + 1'b1;
`ifdef KEY_PARITY_EN
                par_q <= par_q ^ bus.key_in;
                // The trailing parity bit only feeds the accumulator.
                if (key_cnt_q != CNT_W'(KEY_LEN)) begin
                    key_sr_q <= {key_sr_q[KEY_LEN-2:0], bus.key_in};
                end
`else
                key_sr_q <= {key_sr_q[KEY_LEN-2:0], bus.key_in};
`endif
            end
        end
    end

    always_comb begin
        mux_d = '0;
        for (int unsigned i = 0; i < NUM_MUX; i++) begin
            for (int unsigned j = 0; j < NCAND; j++) begin
                if (key_sr_q[i*SEL_W +: SEL_W] == SEL_W'(j)) begin
                    mux_d[i] = bus.cand_i[i*NCAND + j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mux_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid && (state_q == ACTIVE);
            mux_q       <= (bus.in_valid && (state_q == ACTIVE)) ? mux_d : '0;
        end
    end

    assign bus.mux_o     = mux_q;
    assign bus.out_valid = out_valid_q;
    assign bus.key_ready = (state_q == ACTIVE);
    assign bus.key_err   = (state_q == ERROR);
    assign bus.key_cnt   = key_cnt_q;
endmodule

// File: tb/tb_keyed_mux_lock_unit.sv
// Directed plus randomized bench for keyed_mux_lock_unit against a queue-based key model.
module tb_keyed_mux_lock_unit;
    localparam int NUM_MUX = 2;
    localparam int SEL_W   = 2;
    localparam int KEY_LEN = NUM_MUX * SEL_W;
    localparam int NCAND   = 2 ** SEL_W;
`ifdef KEY_PARITY_EN
    localparam int FULL = KEY_LEN + 1;
`else
    localparam int FULL = KEY_LEN;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keyed_mux_lock_if #(.NUM_MUX(NUM_MUX), .SEL_W(SEL_W)) bus ();

    keyed_mux_lock_unit #(.NUM_MUX(NUM_MUX), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: state 0=EMPTY 1=LOADING 2=ACTIVE 3=ERROR; accepted key bits in arrival order.
    int m_state = 0;
    bit m_bits[$];
    int exp_mux = 0;
    int exp_ov = 0;

    function automatic int key_val();
        int v = 0;
        for (int k = 0; k < m_bits.size() && k < KEY_LEN; k++) v = (v << 1) | int'(m_bits[k]);
        return v;
    endfunction

    function automatic bit parity_ok();
`ifdef KEY_PARITY_EN
        bit p = 1'b0;
        foreach (m_bits[k]) p ^= m_bits[k];
        return !p;
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Predict the edge from current inputs, advance one clock, compare every output.
    task automatic step();
        int nmux = 0;
        int nov;
        int ks;
        int sel;
        nov = (rst_n && bus.in_valid && m_state == 2) ? 1 : 0;
        if (nov == 1) begin
            ks = key_val();
            for (int i = 0; i < NUM_MUX; i++) begin
                sel = (ks >> (i * SEL_W)) % NCAND;
                nmux |= ((int'(bus.cand_i) >> (i * NCAND + sel)) & 1) << i;
            end
        end
        if (!rst_n || bus.key_clear) begin
            m_state = 0;
            m_bits.delete();
        end else if (m_state < 2) begin
            if (bus.key_commit) begin
                m_state = (m_bits.size() == FULL && parity_ok()) ? 2 : 3;
            end else if (bus.key_shift) begin
                if (m_bits.size() < FULL) m_bits.push_back(bus.key_in);
                m_state = 1;
            end
        end
        exp_mux = nmux;
        exp_ov  = nov;
        @(posedge clk);
        #1;
        chk("mux_o", bus.mux_o, exp_mux);
        chk("out_valid", bus.out_valid, exp_ov);
        chk("key_ready", bus.key_ready, (m_state == 2) ? 1 : 0);
        chk("key_err", bus.key_err, (m_state == 3) ? 1 : 0);
        chk("key_cnt", bus.key_cnt, m_bits.size());
    endtask

    task automatic drive(input bit clr, input bit com, input bit sh, input bit kin,
                         input bit inv, input logic [7:0] cand);
        bus.key_clear  = clr;
        bus.key_commit = com;
        bus.key_shift  = sh;
        bus.key_in     = kin;
        bus.in_valid   = inv;
        bus.cand_i     = cand;
        step();
    endtask

    task automatic shift(input bit b);
        drive(0, 0, 1, b, 0, 8'h00);
    endtask

    task automatic load_1001();
        shift(1); shift(0); shift(0); shift(1);
`ifdef KEY_PARITY_EN
        shift(0);
`endif
    endtask

    initial begin
        bus.key_clear = 0; bus.key_commit = 0; bus.key_shift = 0;
        bus.key_in = 0; bus.in_valid = 0; bus.cand_i = '0;

        // Reset state
        rst_n = 0;
        drive(0, 0, 1, 1, 1, 8'hFF);
        drive(0, 0, 0, 0, 0, 8'h00);
        chk("rst_cnt", bus.key_cnt, 0);
        chk("rst_ready", bus.key_ready, 0);
        chk("rst_err", bus.key_err, 0);
        chk("rst_ov", bus.out_valid, 0);
        rst_n = 1;

        // Nominal key 1001, first valid output one cycle after in_valid
        load_1001();
        drive(0, 1, 0, 0, 1, 8'b0100_0010);
        chk("commit_ready", bus.key_ready, 1);
        chk("commit_cycle_ov", bus.out_valid, 0);
        drive(0, 0, 0, 0, 1, 8'b0100_0010);
        chk("nom_mux", bus.mux_o, 2'b11);
        chk("nom_ov", bus.out_valid, 1);
        drive(0, 0, 0, 0, 0, 8'b0100_0010);
        chk("nom_ov_drop", bus.out_valid, 0);

        // Clear while streaming
        drive(1, 0, 0, 0, 1, 8'hFF);
        drive(0, 0, 0, 0, 1, 8'hFF);
        chk("clr_ov", bus.out_valid, 0);
        chk("clr_mux", bus.mux_o, 0);
        chk("clr_cnt", bus.key_cnt, 0);

        // Short key -> ERROR, no output
        shift(1); shift(1); shift(0);
        drive(0, 1, 0, 0, 0, 8'h00);
        chk("short_err", bus.key_err, 1);
        chk("short_ready", bus.key_ready, 0);
        drive(0, 1, 1, 1, 1, 8'hFF);
        drive(0, 0, 0, 0, 1, 8'hFF);
        chk("short_ov", bus.out_valid, 0);
        drive(1, 0, 0, 0, 0, 8'h00);
        chk("short_clr_cnt", bus.key_cnt, 0);
        chk("short_clr_err", bus.key_err, 0);

`ifdef KEY_PARITY_EN
        shift(1); shift(0); shift(0); shift(1); shift(0);
        drive(0, 1, 0, 0, 0, 8'h00);
        chk("par_even_ready", bus.key_ready, 1);
        drive(1, 0, 0, 0, 0, 8'h00);
        shift(1); shift(0); shift(0); shift(1); shift(1);
        drive(0, 1, 0, 0, 0, 8'h00);
        chk("par_odd_err", bus.key_err, 1);
        drive(1, 0, 0, 0, 0, 8'h00);
`else
        // Overflow saturates and keeps the first four bits
        shift(1); shift(0); shift(0); shift(1); shift(1); shift(1);
        chk("ovf_cnt", bus.key_cnt, 4);
        drive(0, 1, 0, 0, 0, 8'h00);
        chk("ovf_ready", bus.key_ready, 1);
        drive(0, 0, 0, 0, 1, 8'b0100_0010);
        chk("ovf_mux", bus.mux_o, 2'b11);
        drive(1, 0, 0, 0, 0, 8'h00);
`endif

        // Shift+commit at full count: commit wins, key unchanged
        load_1001();
        drive(0, 1, 1, 1, 0, 8'h00);
        chk("simul_ready", bus.key_ready, 1);
        drive(0, 0, 0, 0, 1, 8'b0100_0010);
        chk("simul_mux", bus.mux_o, 2'b11);
        drive(1, 0, 0, 0, 0, 8'h00);

        // Clear+commit: clear wins
        load_1001();
        drive(1, 1, 0, 0, 0, 8'h00);
        chk("clrcom_ready", bus.key_ready, 0);
        chk("clrcom_cnt", bus.key_cnt, 0);

        // Reset mid-stream
        load_1001();
        drive(0, 1, 0, 0, 0, 8'h00);
        drive(0, 0, 0, 0, 1, 8'hFF);
        chk("pre_rst_ov", bus.out_valid, 1);
        rst_n = 0;
        drive(0, 0, 0, 0, 1, 8'hFF);
        chk("rst_mid_ov", bus.out_valid, 0);
        chk("rst_mid_mux", bus.mux_o, 0);
        chk("rst_mid_ready", bus.key_ready, 0);
        chk("rst_mid_cnt", bus.key_cnt, 0);
        rst_n = 1;

        // Randomized traffic checked by the model inside step()
        for (int n = 0; n < 600; n++) begin
            int r;
            r = int'($urandom_range(0, 63));
            rst_n = (r != 0);
            bus.key_clear  = ($urandom_range(0, 23) == 0);
            bus.key_commit = ($urandom_range(0, 7) == 0);
            bus.key_shift  = ($urandom_range(0, 1) == 1);
            bus.key_in     = $urandom_range(0, 1) == 1;
            bus.in_valid   = $urandom_range(0, 3) != 0;
            bus.cand_i     = 8'($urandom);
            step();
        end
        rst_n = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
